// File: rtl/mda_motor_control_pwm_capture_pkg.sv
// Shared constants for the motor-control PWM capture path: default result
// width and the capture FSM state encodings.
package mda_motor_control_pwm_capture_pkg;

  localparam int PERIOD_LENGTH = 16;

  localparam logic [1:0] PWMCAP_IDLE = 2'd0;
  localparam logic [1:0] PWMCAP_HIGH = 2'd1;
  localparam logic [1:0] PWMCAP_LOW  = 2'd2;

endpackage

// File: rtl/mda_motor_control_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level input with rise/fall
// detection; shared by PWM capture, encoder and limit-switch inputs.
module mda_motor_control_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   dly_d;

  // shift the raw input through the synchronizer and keep one delayed copy
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  // synchronizer and delay flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~dly_q;
  assign fall  = ~sig_s & dly_q;

endmodule

// File: rtl/mda_motor_control_pwm_capture.sv
// PWM receive-side capture: measures period and high time of pwm_in and turns
// them into a 50%-centred direction/magnitude command, with loss-of-signal.
module mda_motor_control_pwm_capture
  import mda_motor_control_pwm_capture_pkg::*;
#(
  parameter int WIDTH       = PERIOD_LENGTH,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             direction,
  output logic [WIDTH-1:0] magnitude,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TO_W = WIDTH'(TIMEOUT);

  logic             pwm_s;
  logic             rise;
  logic             fall;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic [WIDTH-1:0] half_s;
  logic [WIDTH-1:0] diff_s;

  mda_motor_control_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .sig_in (pwm_in),
    .sig_s  (pwm_s),
    .rise   (rise),
    .fall   (fall)
  );

  // capture FSM, counters and result computation; cnt_q is the period on a LOW-state rise
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cnt_d = high_cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    dir_d      = dir_q;
    mag_d      = mag_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    stuck_d    = stuck_q;

    half_s = {1'b0, cnt_q[WIDTH-1:1]};
    if (high_cnt_q >= half_s) begin
      diff_s = high_cnt_q - half_s;
    end else begin
      diff_s = half_s - high_cnt_q;
    end

    if (!enable) begin
      state_d    = PWMCAP_IDLE;
      cnt_d      = '0;
      high_cnt_d = '0;
    end else begin
      case (state_q)
        PWMCAP_IDLE: begin
          if (rise) begin
            state_d = PWMCAP_HIGH;
            cnt_d   = ONE;
          end else begin
            cnt_d = '0;
          end
        end
        PWMCAP_HIGH: begin
          if (fall) begin
            state_d    = PWMCAP_LOW;
            high_cnt_d = cnt_q;
            cnt_d      = cnt_q + ONE;
          end else if (cnt_q == TO_W) begin
            state_d   = PWMCAP_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
            stuck_d   = pwm_s;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        PWMCAP_LOW: begin
          // a rise coinciding with the timeout count still completes the period
          if (rise) begin
            state_d   = PWMCAP_HIGH;
            cnt_d     = ONE;
            period_d  = cnt_q;
            high_d    = high_cnt_q;
            dir_d     = (high_cnt_q >= half_s);
            mag_d     = {diff_s[WIDTH-2:0], 1'b0};
            valid_d   = 1'b1;
            timeout_d = 1'b0;
          end else if (cnt_q == TO_W) begin
            state_d   = PWMCAP_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
            stuck_d   = pwm_s;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = PWMCAP_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // state and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= PWMCAP_IDLE;
      cnt_q      <= '0;
      high_cnt_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      dir_q      <= 1'b0;
      mag_q      <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cnt_q <= high_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      dir_q      <= dir_d;
      mag_q      <= mag_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      stuck_q    <= stuck_d;
    end
  end

  assign period_out  = period_q;
  assign high_out    = high_q;
  assign direction   = dir_q;
  assign magnitude   = mag_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;

endmodule

// File: tb/tb_mda_motor_control_pwm_capture.sv
// Bench for mda_motor_control_pwm_capture: one instance with the default
// timeout for measurement tests, one with TIMEOUT=100 for loss-of-signal.
module tb_mda_motor_control_pwm_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, pwm_a, pwm_b;
  logic [15:0] per_a, high_a, mag_a, per_b, high_b, mag_b;
  logic        dir_a, valid_a, to_a, stuck_a;
  logic        dir_b, valid_b, to_b, stuck_b;

  mda_motor_control_pwm_capture dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_a),
    .period_out(per_a), .high_out(high_a), .direction(dir_a), .magnitude(mag_a),
    .valid(valid_a), .timeout(to_a), .stuck_level(stuck_a)
  );

  mda_motor_control_pwm_capture #(.TIMEOUT(100)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pwm_in(pwm_b),
    .period_out(per_b), .high_out(high_b), .direction(dir_b), .magnitude(mag_b),
    .valid(valid_b), .timeout(to_b), .stuck_level(stuck_b)
  );

  typedef struct { int per; int hi; int dir; int mag; int to; int stamp; } rec_t;
  typedef struct { int p; int h; int e_per; int e_high; int e_dir; int e_mag; } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  rec_t qa[$];
  rec_t qb[$];
  logic pva = 1'b0;
  logic pvb = 1'b0;
  vec_t vecs[9];
  int   ps[10];
  int   hs[10];

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard capture of every valid strobe, plus the never-back-to-back rule
  always @(negedge clk) begin
    if (valid_a) begin
      tests++;
      if (pva) begin fails++; $display("FAIL valid_a_back_to_back cycle=%0d got 1 expected 0", cyc); end
      qa.push_back('{int'(per_a), int'(high_a), int'(dir_a), int'(mag_a), int'(to_a), cyc});
    end
    if (valid_b) begin
      tests++;
      if (pvb) begin fails++; $display("FAIL valid_b_back_to_back cycle=%0d got 1 expected 0", cyc); end
      qb.push_back('{int'(per_b), int'(high_b), int'(dir_b), int'(mag_b), int'(to_b), cyc});
    end
    pva <= valid_a;
    pvb <= valid_b;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference: half is floor(P/2); direction and magnitude from plain integer arithmetic
  function automatic void model(input int p, input int h, output int d, output int m);
    int half;
    half = p / 2;
    d = (h >= half) ? 1 : 0;
    m = (((h >= half) ? (h - half) : (half - h)) * 2) % 65536;
  endfunction

  task automatic setpwm(input int sel, input logic v);
    if (sel == 0) pwm_a = v;
    else pwm_b = v;
  endtask

  task automatic periods(input int sel, input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        setpwm(sel, (i < h));
      end
    end
  endtask

  task automatic final_rise(input int sel);
    @(negedge clk); setpwm(sel, 1'b1);
    @(negedge clk); setpwm(sel, 1'b0);
    repeat (6) @(negedge clk);
  endtask

  task automatic restart_a();
    @(negedge clk);
    enable = 1'b0; pwm_a = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    qa.delete();
  endtask

  task automatic check_run(input string name, input int gap, input int ep, input int eh,
                           input int ed, input int em, input int n);
    chk({name, "_count"}, qa.size(), n);
    for (int k = 0; k < qa.size(); k++) begin
      chk({name, "_period"}, qa[k].per, ep);
      chk({name, "_high"}, qa[k].hi, eh);
      chk({name, "_dir"}, qa[k].dir, ed);
      chk({name, "_mag"}, qa[k].mag, em);
      if (k > 0) chk({name, "_gap"}, qa[k].stamp - qa[k-1].stamp, gap);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_period"}, int'(per_a), 0);
    chk({name, "_high"}, int'(high_a), 0);
    chk({name, "_dir"}, int'(dir_a), 0);
    chk({name, "_mag"}, int'(mag_a), 0);
    chk({name, "_valid"}, int'(valid_a), 0);
    chk({name, "_timeout"}, int'(to_a), 0);
    chk({name, "_stuck"}, int'(stuck_a), 0);
  endtask

  initial begin
    int d, m, c0, t, found;

    vecs[0] = '{1000, 750, 1000, 750, 1, 500};
    vecs[1] = '{1000, 250, 1000, 250, 0, 500};
    vecs[2] = '{1000, 500, 1000, 500, 1, 0};
    vecs[3] = '{999,  499, 999,  499, 1, 0};
    vecs[4] = '{2,    1,   2,    1,   1, 0};
    vecs[5] = '{10,   9,   10,   9,   1, 8};
    vecs[6] = '{10,   1,   10,   1,   0, 8};
    vecs[7] = '{3,    2,   3,    2,   1, 2};
    vecs[8] = '{7,    1,   7,    1,   0, 4};

    reset_n = 1'b0; enable = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset_a");
    chk("reset_b_timeout", int'(to_b), 0);
    chk("reset_b_period", int'(per_b), 0);
    reset_n = 1'b1; enable = 1'b1;

    // three full periods plus a closing rise: three valids, none on the first rise
    for (int i = 0; i < 9; i++) begin
      restart_a();
      periods(0, vecs[i].p, vecs[i].h, 3);
      final_rise(0);
      check_run($sformatf("vec%0d", i), vecs[i].p, vecs[i].e_per, vecs[i].e_high,
                vecs[i].e_dir, vecs[i].e_mag, 3);
    end

    // random period/high sequence, each valid reports the period just finished
    restart_a();
    for (int k = 0; k < 10; k++) begin
      ps[k] = $urandom_range(400, 2);
      hs[k] = $urandom_range(ps[k] - 1, 1);
      periods(0, ps[k], hs[k], 1);
    end
    final_rise(0);
    chk("rand_count", qa.size(), 10);
    for (int k = 0; k < 10 && k < qa.size(); k++) begin
      model(ps[k], hs[k], d, m);
      chk($sformatf("rand%0d_period", k), qa[k].per, ps[k]);
      chk($sformatf("rand%0d_high", k), qa[k].hi, hs[k]);
      chk($sformatf("rand%0d_dir", k), qa[k].dir, d);
      chk($sformatf("rand%0d_mag", k), qa[k].mag, m);
      if (k > 0) chk($sformatf("rand%0d_gap", k), qa[k].stamp - qa[k-1].stamp, ps[k]);
    end

    // enable low: no valid, results held; re-enable needs two rises
    restart_a();
    periods(0, 100, 30, 2);
    final_rise(0);
    qa.delete();
    enable = 1'b0;
    periods(0, 80, 60, 3);
    chk("en_off_valids", qa.size(), 0);
    chk("en_off_period_held", int'(per_a), 100);
    chk("en_off_high_held", int'(high_a), 30);
    chk("en_off_mag_held", int'(mag_a), 40);
    chk("en_off_dir_held", int'(dir_a), 0);
    enable = 1'b1;
    periods(0, 80, 60, 3);
    final_rise(0);
    check_run("en_on", 80, 80, 60, 1, 40, 3);

    // synchronous reset in the middle of a high phase
    restart_a();
    periods(0, 100, 40, 2);
    @(negedge clk); pwm_a = 1'b1;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; pwm_a = 1'b0;
    chk_zero("midreset");
    qa.delete();
    repeat (5) @(negedge clk);
    periods(0, 100, 40, 3);
    final_rise(0);
    check_run("after_reset", 100, 100, 40, 0, 20, 3);

    // loss of signal with the line stuck high, TIMEOUT=100
    @(negedge clk); pwm_b = 1'b1;
    c0 = cyc;
    found = 0; t = -1;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (to_b) begin found = 1; t = cyc; end
    end
    chk("to_found", found, 1);
    chk("to_cycle", t, c0 + 1 + 2 + 100);
    chk("to_stuck_high", int'(stuck_b), 1);

    // recovery: first rise silent, second rise measures and clears timeout
    qb.delete();
    @(negedge clk); pwm_b = 1'b0;
    repeat (20) @(negedge clk);
    periods(1, 50, 10, 1);
    chk("rec_first_rise_valids", qb.size(), 0);
    chk("rec_timeout_still_set", int'(to_b), 1);
    periods(1, 50, 10, 1);
    chk("rec_count", qb.size(), 1);
    if (qb.size() > 0) begin
      chk("rec_period", qb[0].per, 50);
      chk("rec_high", qb[0].hi, 10);
      chk("rec_dir", qb[0].dir, 0);
      chk("rec_mag", qb[0].mag, 30);
      chk("rec_to_cleared", qb[0].to, 0);
    end

    // rise landing exactly on the timeout count wins
    qb.delete();
    periods(1, 100, 10, 1);
    final_rise(1);
    chk("tie_count", qb.size(), 2);
    if (qb.size() > 1) begin
      chk("tie_period", qb[1].per, 100);
      chk("tie_high", qb[1].hi, 10);
      chk("tie_to", qb[1].to, 0);
    end
    chk("tie_to_out", int'(to_b), 0);

    // line stuck low: timeout with stuck_level 0, then periods too long to measure
    repeat (150) @(negedge clk);
    chk("low_to", int'(to_b), 1);
    chk("low_stuck", int'(stuck_b), 0);
    qb.delete();
    periods(1, 101, 10, 2);
    final_rise(1);
    chk("long_period_valids", qb.size(), 0);
    chk("long_period_to", int'(to_b), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
